disbus_master: RTL and testbench
================================

// Module: disbus_master
// PURPOSE
//  Two-wire (I2C-style) bus initiator for the display/clock bus (disdat/disclk).
//  It is the hardware counterpart of the u3090mg responder and replaces slave-MCU bit-banging.
//  It accepts byte-level commands (START, WRITE, READ, STOP) from a local controller.
//  It drives open-drain SCL/SDA, samples ACK/data, and returns one response per WRITE/READ.
// PARAMETERS
//  QDIV      75  clk cycles per quarter SCL period (30 MHz / (4*75) = 100 kHz); legal range 2..255
//  STRETCH   1   1 = honour responder clock stretching (wait while scl_in low after release)
// PORTS
//  clk          in   1  system clock (30 MHz)
//  reset_n      in   1  asynchronous active-low reset
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  command accepted when cmd_valid && cmd_ready
//  cmd_op       in   2  0=START (repeated start if bus owned), 1=WRITE, 2=READ, 3=STOP
//  cmd_wdata    in   8  byte for WRITE
//  cmd_nack     in   1  READ only: 1 = master sends NACK after the byte (last byte)
//  rsp_valid    out  1  one-cycle pulse at the end of WRITE/READ
//  rsp_rdata    out  8  byte received (READ); 0 after WRITE
//  rsp_ack      out  1  WRITE: 1 = responder pulled SDA low in ACK slot; READ: ~cmd_nack
//  busy         out  1  bus owned (between START and completion of STOP)
//  scl_out      out  1  1 = release SCL, 0 = drive low
//  scl_in       in   1  wired-AND SCL level
//  sda_out      out  1  1 = release SDA, 0 = drive low
//  sda_in       in   1  wired-AND SDA level
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_ack=0, busy=0, scl_out=1, sda_out=1.
//  States: IDLE, START, BIT, STOP, plus a 2-bit quarter phase q (0..3) and a 4-bit bit index.
//  Each state runs QDIV clk per quarter, counted by an 8-bit divider reloaded at every phase step.
//  cmd_ready=1 only in IDLE or in BUS_HELD (busy, SCL low, waiting); it drops the cycle after acceptance.
//  START from IDLE
//   q0: SDA=1, SCL=1.
//   q1: SDA=0.
//   q2: SCL=0.
//   Then BUS_HELD with busy=1.
//  START while busy
//   q0: SDA=1, SCL low.
//   q1: SCL=1.
//   q2: SDA=0.
//   q3: SCL=0.
//  BIT (9 slots, MSB first; slot 8 is ACK), per slot:
//   q0: set SDA; SCL low.
//   q1: release SCL.
//   q2: sample sda_in on the last cycle of the quarter.
//   q3: SCL low.
//   WRITE: bits from cmd_wdata; SDA released in slot 8, and ack = !sda_in.
//   READ: SDA released in slots 0..7, and sampled bits shift into rdata; slot 8 drives SDA = cmd_nack.
//  rsp_valid pulses for one cycle after q3 of slot 8; rsp_* hold until the next response.
//  STOP: q0 SDA=0; q1 SCL=1; q2 SDA=1; q3 idle hold. Then IDLE with busy=0.
//  STOP while not busy: no bus activity; completes in 1 cycle, no rsp.
//  WRITE/READ while not busy: ignored; no bus activity, no rsp, cmd_ready back next cycle.
//  Clock stretching (STRETCH=1)
//   In q1 (and START/STOP SCL-release quarters) the divider does not start until scl_in==1.
//   The stretch timeout is unbounded.
//  Divider arithmetic: unsigned 8-bit; reload value QDIV-1; step on count==0. No wrap beyond that.
//  Async reset mid-transfer: lines released immediately (glitch-free via registered outputs); no STOP is generated.
//  Outputs scl_out/sda_out are registered; changes occur only on phase boundaries.
// STRUCTURE
//  Package disbus_pkg: typedef enum logic [1:0] {OP_START, OP_WRITE, OP_READ, OP_STOP};
//  also the state enum and the QDIV default.
//  Sub-module disbus_qdiv: quarter-period tick generator with a hold input (stretch) and restart.
//  Everything else is one FSM in disbus_master.
// TESTING (bench uses QDIV=4 and a u3090mg model on a wired-AND bus)
//  1. START, WRITE 8'hA0, STOP: SCL shows 9 high pulses; bits seen 1,0,1,0,0,0,0,0; rsp_ack=1 from the model; busy 1->0.
//  2. WRITE to an absent address (responder silent): rsp_ack=0, rsp_rdata=0; the following STOP still completes.
//  3. START, WRITE A0, WRITE 05, START, WRITE A1, READ nack=0, READ nack=1, STOP:
//     - repeated start timing is correct;
//     - the two rdata values match the model registers 5 and 6;
//     - SDA is low in the ACK slot of the first READ and high in the second.
//  4. Responder holds scl_in low for 37 cycles in bit 3: q1 extends by exactly 37 cycles; data integrity is kept.
//  5. Deassert reset_n during bit 4 of a WRITE: scl_out=sda_out=1 and busy=0 asynchronously;
//     after release a START is accepted on the first cycle.
//  6. WRITE with busy=0: zero SCL/SDA edges, no rsp_valid, cmd_ready returns high the next cycle.

Source files
------------

// File: rtl/disbus_pkg.sv
// Shared types and constants for the display/clock bus initiator.
package disbus_pkg;

  localparam int unsigned QDIV_DEF = 75;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned BIT_W    = 4;
  localparam logic [BIT_W-1:0] ACK_SLOT = BIT_W'(8);

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD  = 3'd1,
    ST_START = 3'd2,
    ST_BIT   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  // Quarters in which SCL has just been released and a responder may stretch it.
  function automatic logic is_rel_q(input state_e st, input logic [1:0] q, input logic rep);
    return (q == 2'd1) && ((st == ST_BIT) || (st == ST_STOP) || ((st == ST_START) && rep));
  endfunction

endpackage

// File: rtl/disbus_qdiv.sv
// Quarter-SCL-period tick generator; parks at the reload value while not running.
module disbus_qdiv
  import disbus_pkg::*;
#(
  parameter int unsigned QDIV = QDIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_hold,
  output logic o_tick_c
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(QDIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick_c = i_run && !i_hold && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= RELOAD;
    end else if (!i_run || o_tick_c) begin
      r_cnt <= RELOAD;
    end else if (!i_hold) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/disbus_master.sv
// Byte-level two-wire bus initiator: START / WRITE / READ / STOP commands
// become open-drain SCL/SDA waveforms built from four quarters per bit.
module disbus_master
  import disbus_pkg::*;
#(
  parameter int unsigned QDIV    = QDIV_DEF,
  parameter bit          STRETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_ack,
  output logic       busy,
  output logic       scl_out,
  input  logic       scl_in,
  output logic       sda_out,
  input  logic       sda_in
);

  state_e           r_state;
  logic [1:0]       r_q;
  logic [BIT_W-1:0] r_bit;
  logic [7:0]       r_shift;
  logic             r_wr;
  logic             r_nack;
  logic             r_ack;
  logic             r_rep;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_rsp_ack;
  logic             r_busy;
  logic             r_scl;
  logic             r_sda;

  logic w_accept;
  logic w_run;
  logic w_hold;
  logic w_tick;
  op_e  w_op;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_op     = op_e'(cmd_op);
  assign w_run    = (r_state == ST_START) || (r_state == ST_BIT) || (r_state == ST_STOP);
  assign w_hold   = STRETCH && is_rel_q(r_state, r_q, r_rep) && !scl_in;

  disbus_qdiv #(.QDIV(QDIV)) u_qdiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_run    (w_run),
    .i_hold   (w_hold),
    .o_tick_c (w_tick)
  );

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_ack   = r_rsp_ack;
  assign busy      = r_busy;
  assign scl_out   = r_scl;
  assign sda_out   = r_sda;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_q         <= 2'd0;
      r_bit       <= '0;
      r_shift     <= 8'h00;
      r_wr        <= 1'b0;
      r_nack      <= 1'b0;
      r_ack       <= 1'b0;
      r_rep       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HELD: begin
          // Commands that need the bus are swallowed in IDLE; ready returns next cycle.
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_q         <= 2'd0;
            case (w_op)
              OP_START: begin
                r_state <= ST_START;
                r_rep   <= (r_state == ST_HELD);
                r_busy  <= 1'b1;
                r_sda   <= 1'b1;
              end
              OP_WRITE, OP_READ: begin
                if (r_state == ST_HELD) begin
                  r_state <= ST_BIT;
                  r_bit   <= '0;
                  r_wr    <= (w_op == OP_WRITE);
                  r_nack  <= cmd_nack;
                  r_shift <= (w_op == OP_WRITE) ? cmd_wdata : 8'h00;
                  r_sda   <= (w_op == OP_WRITE) ? cmd_wdata[7] : 1'b1;
                end
              end
              OP_STOP: begin
                if (r_state == ST_HELD) begin
                  r_state <= ST_STOP;
                  r_sda   <= 1'b0;
                end
              end
              default: ;
            endcase
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        // From idle: SDA falls under high SCL in 3 quarters; repeated start re-raises SCL first.
        ST_START: begin
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_q <= 2'd1;
                if (r_rep) r_scl <= 1'b1;
                else       r_sda <= 1'b0;
              end
              2'd1: begin
                r_q <= 2'd2;
                if (r_rep) r_sda <= 1'b0;
                else       r_scl <= 1'b0;
              end
              2'd2: begin
                if (r_rep) begin
                  r_q   <= 2'd3;
                  r_scl <= 1'b0;
                end else begin
                  r_q         <= 2'd0;
                  r_state     <= ST_HELD;
                  r_cmd_ready <= 1'b1;
                end
              end
              default: begin
                r_q         <= 2'd0;
                r_state     <= ST_HELD;
                r_cmd_ready <= 1'b1;
              end
            endcase
          end
        end

        ST_BIT: begin
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_q   <= 2'd1;
                r_scl <= 1'b1;
              end
              2'd1: r_q <= 2'd2;
              2'd2: begin
                r_q   <= 2'd3;
                r_scl <= 1'b0;
                if (r_bit == ACK_SLOT) r_ack <= r_wr ? !sda_in : !r_nack;
                else if (!r_wr)        r_shift <= {r_shift[6:0], sda_in};
              end
              default: begin
                r_q <= 2'd0;
                if (r_bit == ACK_SLOT) begin
                  r_state     <= ST_HELD;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_wr ? 8'h00 : r_shift;
                  r_rsp_ack   <= r_ack;
                end else begin
                  r_bit <= r_bit + 1'b1;
                  if (r_bit == ACK_SLOT - 1'b1) r_sda <= r_wr ? 1'b1 : r_nack;
                  else                          r_sda <= r_wr ? r_shift[6] : 1'b1;
                  if (r_wr) r_shift <= {r_shift[6:0], 1'b0};
                end
              end
            endcase
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_q   <= 2'd1;
                r_scl <= 1'b1;
              end
              2'd1: begin
                r_q   <= 2'd2;
                r_sda <= 1'b1;
              end
              2'd2: r_q <= 2'd3;
              default: begin
                r_q         <= 2'd0;
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_cmd_ready <= 1'b1;
              end
            endcase
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disbus_master.sv
// Directed bench for disbus_master with a behavioural u3090mg responder on a wired-AND bus.
module tb_disbus_master;
  import disbus_pkg::*;

  localparam int unsigned QD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_ack;
  logic       busy;
  logic       scl_out;
  logic       sda_out;
  logic       scl_pull = 1'b0;
  logic       m_sda_pull;
  logic       scl_bus;
  logic       sda_bus;

  assign scl_bus = scl_out & ~scl_pull;
  assign sda_bus = sda_out & ~m_sda_pull;

  always #5 clk = ~clk;

  disbus_master #(.QDIV(QD), .STRETCH(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_ack   (rsp_ack),
    .busy      (busy),
    .scl_out   (scl_out),
    .scl_in    (scl_bus),
    .sda_out   (sda_out),
    .sda_in    (sda_bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Bus monitor: SCL high-pulse widths, SDA at each SCL rise, edge and response counts.
  int         mon_rises = 0;
  int         mon_edges = 0;
  int         mon_rsp   = 0;
  int         mon_cur   = 0;
  int         mon_w [256];
  logic [8:0] mon_bits  = '0;
  logic       mon_pscl  = 1'b1;
  logic       mon_psda  = 1'b1;

  always @(negedge clk) begin
    if (scl_out && !mon_pscl) begin
      mon_bits = {mon_bits[7:0], sda_bus};
      mon_rises++;
      mon_cur = 0;
    end
    if (scl_out) mon_cur++;
    if (!scl_out && mon_pscl && mon_rises > 0) mon_w[8'(mon_rises - 1)] = mon_cur;
    if (scl_out != mon_pscl) mon_edges++;
    if (sda_out != mon_psda) mon_edges++;
    if (rsp_valid) mon_rsp++;
    mon_pscl = scl_out;
    mon_psda = sda_out;
  end

  // u3090mg responder at 7-bit address 0x50 with a register pointer.
  logic [7:0] m_regs [16];
  initial begin : u3090mg
    logic ps, pd, s, d, m_act, m_rd, m_nacked;
    logic [7:0] m_sh, m_out, m_ptr;
    int m_rise, m_idx;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h10 + 8'(i);
    m_regs[5] = 8'h5A;
    m_regs[6] = 8'hC3;
    m_sda_pull = 1'b0;
    ps = 1'b1; pd = 1'b1; m_act = 1'b0; m_rd = 1'b0; m_nacked = 1'b0;
    m_sh = '0; m_out = '0; m_ptr = '0; m_rise = 0; m_idx = 0;
    forever begin
      @(negedge clk);
      s = scl_bus;
      d = sda_bus;
      if (ps && s && pd && !d) begin
        m_act = 1'b1; m_rd = 1'b0; m_rise = 0; m_idx = 0; m_sda_pull = 1'b0;
      end else if (ps && s && !pd && d) begin
        m_act = 1'b0; m_sda_pull = 1'b0;
      end else if (m_act && !ps && s) begin
        m_rise++;
        if (m_rise <= 8 && !m_rd) m_sh = {m_sh[6:0], d};
        if (m_rise == 9 && m_rd) m_nacked = d;
      end else if (m_act && ps && !s) begin
        if (m_rise == 8) begin
          if (!m_rd) begin
            if (m_idx == 0) begin
              if (m_sh[7:1] == 7'h50) begin
                m_sda_pull = 1'b1;
                m_rd = m_sh[0];
              end else begin
                m_act = 1'b0;
              end
            end else begin
              if (m_idx == 1) m_ptr = m_sh;
              else begin
                m_regs[m_ptr[3:0]] = m_sh;
                m_ptr = m_ptr + 8'd1;
              end
              m_sda_pull = 1'b1;
            end
          end else begin
            m_sda_pull = 1'b0;
          end
        end else if (m_rise == 9) begin
          m_rise = 0;
          m_idx++;
          if (m_rd && !m_nacked) begin
            m_out = m_regs[m_ptr[3:0]];
            m_ptr = m_ptr + 8'd1;
            m_sda_pull = !m_out[7];
          end else begin
            m_sda_pull = 1'b0;
          end
        end else if (m_rd && m_rise >= 1 && m_rise <= 7) begin
          m_sda_pull = !m_out[3'(7 - m_rise)];
        end
      end
      ps = s;
      pd = d;
    end
  end

  task automatic send(input op_e op, input logic [7:0] wd, input logic nk);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_wdata = wd;
    cmd_nack  = nk;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 4000);
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin : main
    int cyc, base, e0, r0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ack", 32'(rsp_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scl", 32'(scl_out), 32'd1);
    chk("rst_sda", 32'(sda_out), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: START, WRITE A0, STOP
    send(OP_START, 8'h00, 1'b0);
    chk("t1_busy_set", 32'(busy), 32'd1);
    wait_ready(cyc);
    chk("t1_start_cyc", 32'(cyc), 32'd12);
    send(OP_WRITE, 8'hA0, 1'b0);
    base = mon_rises;
    wait_rsp(cyc);
    chk("t1_write_cyc", 32'(cyc), 32'd144);
    chk("t1_rises", 32'(mon_rises - base), 32'd9);
    chk("t1_bits", 32'(mon_bits), 32'h140);
    chk("t1_ack", 32'(rsp_ack), 32'd1);
    chk("t1_rdata", 32'(rsp_rdata), 32'd0);
    chk("t1_width0", 32'(mon_w[8'(base)]), 32'd8);
    @(posedge clk); #1;
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    send(OP_STOP, 8'h00, 1'b0);
    wait_ready(cyc);
    chk("t1_stop_cyc", 32'(cyc), 32'd16);
    chk("t1_busy_clr", 32'(busy), 32'd0);
    chk("t1_scl_idle", 32'(scl_out), 32'd1);
    chk("t1_sda_idle", 32'(sda_out), 32'd1);

    // 3: pointer write, repeated start, two reads
    send(OP_START, 8'h00, 1'b0);
    wait_ready(cyc);
    send(OP_WRITE, 8'hA0, 1'b0);
    wait_rsp(cyc);
    chk("t3_addr_ack", 32'(rsp_ack), 32'd1);
    send(OP_WRITE, 8'h05, 1'b0);
    wait_rsp(cyc);
    chk("t3_ptr_ack", 32'(rsp_ack), 32'd1);
    send(OP_START, 8'h00, 1'b0);
    wait_ready(cyc);
    chk("t3_rstart_cyc", 32'(cyc), 32'd16);
    chk("t3_rstart_busy", 32'(busy), 32'd1);
    send(OP_WRITE, 8'hA1, 1'b0);
    wait_rsp(cyc);
    chk("t3_rd_addr_ack", 32'(rsp_ack), 32'd1);
    send(OP_READ, 8'h00, 1'b0);
    wait_rsp(cyc);
    chk("t3_rd1_data", 32'(rsp_rdata), 32'h5A);
    chk("t3_rd1_ack", 32'(rsp_ack), 32'd1);
    chk("t3_rd1_bits", 32'(mon_bits), 32'h0B4);
    send(OP_READ, 8'h00, 1'b1);
    wait_rsp(cyc);
    chk("t3_rd2_data", 32'(rsp_rdata), 32'hC3);
    chk("t3_rd2_ack", 32'(rsp_ack), 32'd0);
    chk("t3_rd2_bits", 32'(mon_bits), 32'h187);
    send(OP_STOP, 8'h00, 1'b0);
    wait_ready(cyc);
    chk("t3_busy_clr", 32'(busy), 32'd0);

    // 2: absent responder
    send(OP_START, 8'h00, 1'b0);
    wait_ready(cyc);
    send(OP_WRITE, 8'hC4, 1'b0);
    wait_rsp(cyc);
    chk("t2_ack", 32'(rsp_ack), 32'd0);
    chk("t2_rdata", 32'(rsp_rdata), 32'd0);
    chk("t2_bits", 32'(mon_bits), 32'h189);
    send(OP_STOP, 8'h00, 1'b0);
    wait_ready(cyc);
    chk("t2_stop_cyc", 32'(cyc), 32'd16);
    chk("t2_busy_clr", 32'(busy), 32'd0);

    // 4: responder stretches SCL for 37 cycles in bit 3
    send(OP_START, 8'h00, 1'b0);
    wait_ready(cyc);
    send(OP_WRITE, 8'hA0, 1'b0);
    base = mon_rises;
    cyc = 0;
    while (!((mon_rises - base) == 3 && !scl_out) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    scl_pull = 1'b1;
    cyc = 0;
    while (!scl_out && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t4_release_seen", 32'(scl_out), 32'd1);
    repeat (37) @(posedge clk);
    #1;
    scl_pull = 1'b0;
    wait_rsp(cyc);
    chk("t4_width_b3", 32'(mon_w[8'(base + 3)]), 32'd45);
    chk("t4_width_b2", 32'(mon_w[8'(base + 2)]), 32'd8);
    chk("t4_width_b4", 32'(mon_w[8'(base + 4)]), 32'd8);
    chk("t4_bits", 32'(mon_bits), 32'h140);
    chk("t4_ack", 32'(rsp_ack), 32'd1);
    send(OP_STOP, 8'h00, 1'b0);
    wait_ready(cyc);

    // 6: WRITE and STOP while bus not owned
    e0 = mon_edges;
    r0 = mon_rsp;
    send(OP_WRITE, 8'h55, 1'b0);
    chk("t6_ready_drop", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("t6_ready_back", 32'(cmd_ready), 32'd1);
    send(OP_STOP, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("t6_stop_ready", 32'(cmd_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_edges", 32'(mon_edges - e0), 32'd0);
    chk("t6_rsp", 32'(mon_rsp - r0), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    // 5: asynchronous reset in bit 4 of a WRITE
    send(OP_START, 8'h00, 1'b0);
    wait_ready(cyc);
    send(OP_WRITE, 8'hA0, 1'b0);
    base = mon_rises;
    cyc = 0;
    while (!((mon_rises - base) == 5 && !scl_out) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_pre_scl", 32'(scl_out), 32'd0);
    chk("t5_pre_sda", 32'(sda_out), 32'd0);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_scl", 32'(scl_out), 32'd1);
    chk("t5_rst_sda", 32'(sda_out), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    chk("t5_ready_after", 32'(cmd_ready), 32'd1);
    cmd_op    = OP_START;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("t5_start_taken", 32'(busy), 32'd1);
    chk("t5_ready_drop", 32'(cmd_ready), 32'd0);
    wait_ready(cyc);
    chk("t5_start_cyc", 32'(cyc), 32'd12);
    send(OP_STOP, 8'h00, 1'b0);
    wait_ready(cyc);
    chk("t5_busy_clr", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
